// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its queue.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fetch_pkg;

   // Fetch control states
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } fetch_state_e;

   // Every instruction is one fixed-size word
   localparam int unsigned INST_BYTES = 4;

   // Sticky error flag layout
   localparam int unsigned ERR_W         = 2;
   localparam int unsigned ERR_UNEXP_RSP = 0;
   localparam int unsigned ERR_MISALIGN  = 1;

   // Drop counter width: covers up to 255 abandoned memory responses
   localparam int unsigned DROP_W = 8;

   // A target is misaligned when either low address bit is set
   function automatic logic is_misaligned(input logic [1:0] addr_lo);
      return addr_lo != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundles the memory request/response and decode handshakes of the fetch unit.
// Latency: wires only.
// Backpressure: valid/ready on request and decode sides; responses cannot stall.
interface fetch_if #(
   parameter int XLEN = 64,
   parameter int ILEN = 32
);

   // Memory request channel
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;

   // Memory response channel (in order, no ready)
   logic            imem_rsp_valid;
   logic [ILEN-1:0] imem_rsp_data;

   // Decode channel
   logic            inst_valid;
   logic            inst_ready;
   logic [ILEN-1:0] inst_data;
   logic [XLEN-1:0] inst_pc;

   // Fetch unit side
   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      output inst_valid,
      output inst_data,
      output inst_pc,
      input  inst_ready
   );

   // Memory and decode side
   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data,
      input  inst_valid,
      input  inst_data,
      input  inst_pc,
      output inst_ready
   );

endinterface

// File: rtl/fetch_ring.sv
// Fetch queue: slots are reserved at request time, filled in order by responses, popped by decode.
// Latency: a fill is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller never allocates into a full ring nor fills an unreserved slot.
module fetch_ring
   import fetch_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   alloc_i,
   input  logic [XLEN-1:0]        alloc_pc_i,
   input  logic                   fill_i,
   input  logic [ILEN-1:0]        fill_data_i,
   input  logic                   pop_i,
   output logic [$clog2(DEPTH):0] occ_o,
   output logic [$clog2(DEPTH):0] pend_o,
   output logic                   head_vld_o,
   output logic [ILEN-1:0]        head_data_o,
   output logic [XLEN-1:0]        head_pc_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   // Ordering invariant: rd_q <= fill_q <= alloc_q (modulo wrap).
   logic [PW-1:0]   alloc_q, alloc_d;
   logic [PW-1:0]   fill_q,  fill_d;
   logic [PW-1:0]   rd_q,    rd_d;
   logic [ILEN-1:0] data_q [DEPTH];
   logic [XLEN-1:0] pc_q   [DEPTH];

   // Pointer advance; a flush empties the ring and overrides any same-cycle activity
   always_comb begin
      alloc_d = alloc_q;
      fill_d  = fill_q;
      rd_d    = rd_q;
      if (flush_i) begin
         alloc_d = '0;
         fill_d  = '0;
         rd_d    = '0;
      end else begin
         if (alloc_i) alloc_d = alloc_q + PW'(1);
         if (fill_i)  fill_d  = fill_q  + PW'(1);
         if (pop_i)   rd_d    = rd_q    + PW'(1);
      end
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alloc_q <= '0;
         fill_q  <= '0;
         rd_q    <= '0;
      end else begin
         alloc_q <= alloc_d;
         fill_q  <= fill_d;
         rd_q    <= rd_d;
      end
   end

   // Slot payload: PC tag written at reservation, instruction written at fill
   always_ff @(posedge clk) begin
      if (alloc_i && !flush_i) pc_q[alloc_q[AW-1:0]]  <= alloc_pc_i;
      if (fill_i  && !flush_i) data_q[fill_q[AW-1:0]] <= fill_data_i;
   end

   // Occupancy counts reserved slots; pending counts reserved-but-unfilled ones
   always_comb begin
      occ_o       = alloc_q - rd_q;
      pend_o      = alloc_q - fill_q;
      head_vld_o  = (fill_q != rd_q);
      head_data_o = data_q[rd_q[AW-1:0]];
      head_pc_o   = pc_q[rd_q[AW-1:0]];
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, credit-limited memory requests, in-order queue, redirect flush.
// Latency: request to decode-valid is memory latency + 1 cycle; one instruction per cycle sustained.
// Backpressure: requests stop when reserved slots reach DEPTH; decode stalls hold the queue head.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              ILEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_en,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_base,
   input  logic [XLEN-1:0]  redirect_offset,
   fetch_if.master          bus,
   output logic [ERR_W-1:0] err
);

   localparam int                CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
   localparam logic [XLEN-1:0]   STEP    = XLEN'(INST_BYTES);

   fetch_state_e      state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic [ERR_W-1:0]  err_q, err_d;

   logic [CW-1:0]     occ;
   logic [CW-1:0]     pend;
   logic              head_vld;
   logic [ILEN-1:0]   head_data;
   logic [XLEN-1:0]   head_pc;

   logic              req_vld;
   logic              req_fire;
   logic              rsp_drop;
   logic              rsp_fill;
   logic              rsp_unexp;
   logic              pop;
   logic [XLEN-1:0]   target;

   // Fetch enable FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (fetch_en)  state_d = ST_FETCH;
         ST_FETCH: if (!fetch_en) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // Handshake decode: issue only with a free reserved slot and never in a redirect cycle
   always_comb begin
      req_vld   = (state_q == ST_FETCH) && (occ < DEPTH_C) && !redirect_valid;
      req_fire  = req_vld && bus.imem_req_ready;
      // Responses owed to flushed requests are consumed before any live ones
      rsp_drop  = bus.imem_rsp_valid && (drop_q != '0);
      rsp_fill  = bus.imem_rsp_valid && (drop_q == '0) && (pend != '0);
      rsp_unexp = bus.imem_rsp_valid && (drop_q == '0) && (pend == '0);
      pop       = head_vld && bus.inst_ready;
      target    = redirect_base + redirect_offset;
   end

   // PC, drop accounting and sticky errors: next state
   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      err_d  = err_q;

      if (rsp_drop) drop_d = drop_q - DROP_W'(1);
      if (rsp_unexp) err_d[ERR_UNEXP_RSP] = 1'b1;

      if (redirect_valid) begin
         pc_d = {target[XLEN-1:2], 2'b00};
         if (is_misaligned(target[1:0])) err_d[ERR_MISALIGN] = 1'b1;
         // A live response landing this cycle already retires one pending slot
         drop_d = drop_d + DROP_W'(pend) - (rsp_fill ? DROP_W'(1) : DROP_W'(0));
      end else if (req_fire) begin
         pc_d = pc_q + STEP;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         drop_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
      end
   end

   fetch_ring #(
      .XLEN  (XLEN),
      .ILEN  (ILEN),
      .DEPTH (DEPTH)
   ) u_ring (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect_valid),
      .alloc_i     (req_fire),
      .alloc_pc_i  (pc_q),
      .fill_i      (rsp_fill),
      .fill_data_i (bus.imem_rsp_data),
      .pop_i       (pop),
      .occ_o       (occ),
      .pend_o      (pend),
      .head_vld_o  (head_vld),
      .head_data_o (head_data),
      .head_pc_o   (head_pc)
   );

   // Output drive
   always_comb begin
      bus.imem_req_valid = req_vld;
      bus.imem_req_addr  = pc_q;
      bus.inst_valid     = head_vld;
      bus.inst_data      = head_data;
      bus.inst_pc        = head_pc;
      err                = err_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order variable-latency memory model.
// Latency: memory answers mem_lat cycles after each request handshake.
// Backpressure: memory always accepts; decode readiness is driven by the test tasks.
module tb_fetch_unit;

   localparam int XLEN  = 64;
   localparam int ILEN  = 32;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            fetch_en = 1'b0;
   logic            redirect_valid = 1'b0;
   logic [XLEN-1:0] redirect_base = '0;
   logic [XLEN-1:0] redirect_offset = '0;
   logic [1:0]      err;

   int tests = 0;
   int fails = 0;
   int main_cyc = 0;
   int mem_cyc = 0;
   int mem_lat = 1;
   logic inject = 1'b0;

   logic [XLEN-1:0] pq_addr[$];
   int              pq_due[$];

   fetch_if #(.XLEN(XLEN), .ILEN(ILEN)) bus();

   fetch_unit #(
      .XLEN     (XLEN),
      .ILEN     (ILEN),
      .DEPTH    (DEPTH),
      .RESET_PC (64'd0)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_en        (fetch_en),
      .redirect_valid  (redirect_valid),
      .redirect_base   (redirect_base),
      .redirect_offset (redirect_offset),
      .bus             (bus),
      .err             (err)
   );

   always #5 clk = ~clk;

   // Memory contents: instruction word derived from its address
   function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
      return a[31:0] ^ 32'h5A5A_0000;
   endfunction

   // Memory model: sample handshakes at the edge, drive the next response 1 time unit later
   initial begin
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         mem_cyc++;
         if (!rst) begin
            pq_addr.delete();
            pq_due.delete();
         end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            pq_addr.push_back(bus.imem_req_addr);
            pq_due.push_back(mem_cyc + mem_lat);
         end
         #1;
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
         if (rst) begin
            if (pq_addr.size() > 0 && pq_due[0] <= mem_cyc + 1) begin
               bus.imem_rsp_valid = 1'b1;
               bus.imem_rsp_data  = mem_word(pq_addr.pop_front());
               void'(pq_due.pop_front());
            end else if (inject) begin
               bus.imem_rsp_valid = 1'b1;
               bus.imem_rsp_data  = 32'hBAD0_0000;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      main_cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      fetch_en = 1'b0;
      redirect_valid = 1'b0;
      bus.inst_ready = 1'b0;
      inject = 1'b0;
      mem_lat = 1;
      repeat (3) tick();
      rst = 1'b1;
   endtask

   // Waits up to budget cycles for a decode handshake and reports what was delivered
   task automatic wait_pop(input int budget, output logic ok, output logic [XLEN-1:0] pc,
                           output logic [ILEN-1:0] dat, output int at);
      ok = 1'b0; pc = '0; dat = '0; at = 0;
      for (int i = 0; i < budget; i++) begin
         if (bus.inst_valid && bus.inst_ready) begin
            ok = 1'b1; pc = bus.inst_pc; dat = bus.inst_data; at = main_cyc;
            tick();
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      fetch_en = 1'b1;
      repeat (2) tick();
      tests++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
      tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b expected 0", bus.inst_valid); end
      tests++; if (err !== 2'b00) begin fails++; $display("FAIL reset_err: got %b expected 00", err); end
   endtask

   task automatic test_stream();
      logic ok; logic [XLEN-1:0] pc; logic [ILEN-1:0] d; int at; int prev;
      logic [XLEN-1:0] exp_pc [4];
      logic [ILEN-1:0] exp_d  [4];
      exp_pc = '{64'h0, 64'h4, 64'h8, 64'hC};
      exp_d  = '{32'h5A5A_0000, 32'h5A5A_0004, 32'h5A5A_0008, 32'h5A5A_000C};
      do_reset();
      mem_lat = 1; bus.inst_ready = 1'b1; fetch_en = 1'b1;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_pop(30, ok, pc, d, at);
         tests++; if (!ok || pc !== exp_pc[k]) begin fails++; $display("FAIL stream_pc[%0d]: got %h (ok=%b) expected %h", k, pc, ok, exp_pc[k]); end
         tests++; if (d !== exp_d[k]) begin fails++; $display("FAIL stream_data[%0d]: got %h expected %h", k, d, exp_d[k]); end
         if (k > 0) begin
            tests++; if (at - prev != 1) begin fails++; $display("FAIL stream_rate[%0d]: gap %0d cycles expected 1", k, at - prev); end
         end
         prev = at;
      end
   endtask

   task automatic test_backpressure();
      int hs;
      do_reset();
      mem_lat = 1; bus.inst_ready = 1'b0; fetch_en = 1'b1;
      hs = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus.imem_req_valid && bus.imem_req_ready) hs++;
         tick();
      end
      tests++; if (hs != 4) begin fails++; $display("FAIL bp_requests: got %0d expected 4", hs); end
      tests++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_req_stalled: got %b expected 0", bus.imem_req_valid); end
      tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h0) begin fails++; $display("FAIL bp_head: valid %b pc %h expected 1 / 0", bus.inst_valid, bus.inst_pc); end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      tests++; if (bus.inst_pc !== 64'h4) begin fails++; $display("FAIL bp_after_pop_pc: got %h expected 4", bus.inst_pc); end
      tests++; if (bus.imem_req_valid !== 1'b1) begin fails++; $display("FAIL bp_req_resume: got %b expected 1", bus.imem_req_valid); end
   endtask

   task automatic test_redirect_drop();
      int cnt; logic hs; logic ok; logic [XLEN-1:0] pc; logic [ILEN-1:0] d; int at;
      do_reset();
      mem_lat = 3; bus.inst_ready = 1'b0; fetch_en = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20 && cnt < 3; i++) begin
         hs = bus.imem_req_valid && bus.imem_req_ready;
         tick();
         if (hs) cnt++;
      end
      tests++; if (cnt != 3) begin fails++; $display("FAIL redir_inflight: got %0d expected 3", cnt); end
      redirect_valid = 1'b1; redirect_base = 64'h100; redirect_offset = 64'h20;
      tick();
      redirect_valid = 1'b0;
      tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL redir_flushed: got %b expected 0", bus.inst_valid); end
      bus.inst_ready = 1'b1;
      wait_pop(30, ok, pc, d, at);
      tests++; if (!ok || pc !== 64'h120) begin fails++; $display("FAIL redir_first_pc: got %h (ok=%b) expected 120", pc, ok); end
      tests++; if (d !== 32'h5A5A_0120) begin fails++; $display("FAIL redir_first_data: got %h expected 5a5a0120", d); end
      wait_pop(30, ok, pc, d, at);
      tests++; if (!ok || pc !== 64'h124 || d !== 32'h5A5A_0124) begin fails++; $display("FAIL redir_second: pc %h data %h expected 124 / 5a5a0124", pc, d); end
      tests++; if (err !== 2'b00) begin fails++; $display("FAIL redir_err: got %b expected 00", err); end
   endtask

   task automatic test_misaligned();
      logic ok; logic [XLEN-1:0] pc; logic [ILEN-1:0] d; int at;
      do_reset();
      mem_lat = 1; bus.inst_ready = 1'b1; fetch_en = 1'b1;
      repeat (4) tick();
      redirect_valid = 1'b1; redirect_base = 64'h100; redirect_offset = 64'h2;
      tick();
      redirect_valid = 1'b0;
      tests++; if (err !== 2'b10) begin fails++; $display("FAIL misalign_err: got %b expected 10", err); end
      tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL misalign_flush: got %b expected 0", bus.inst_valid); end
      wait_pop(30, ok, pc, d, at);
      tests++; if (!ok || pc !== 64'h100 || d !== 32'h5A5A_0100) begin fails++; $display("FAIL misalign_restart: pc %h data %h expected 100 / 5a5a0100", pc, d); end
   endtask

   task automatic test_spurious();
      logic ok; logic [XLEN-1:0] pc; logic [ILEN-1:0] d; int at;
      do_reset();
      fetch_en = 1'b0; bus.inst_ready = 1'b0;
      inject = 1'b1;
      tick();
      inject = 1'b0;
      repeat (3) tick();
      tests++; if (err !== 2'b01) begin fails++; $display("FAIL spurious_err: got %b expected 01", err); end
      tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL spurious_queue: got %b expected 0", bus.inst_valid); end
      mem_lat = 1; bus.inst_ready = 1'b1; fetch_en = 1'b1;
      wait_pop(30, ok, pc, d, at);
      tests++; if (!ok || pc !== 64'h0 || d !== 32'h5A5A_0000) begin fails++; $display("FAIL spurious_next: pc %h data %h expected 0 / 5a5a0000", pc, d); end
      tests++; if (err !== 2'b01) begin fails++; $display("FAIL spurious_sticky: got %b expected 01", err); end
   endtask

   task automatic test_wrap();
      logic ok; logic [XLEN-1:0] pc; logic [ILEN-1:0] d; int at;
      do_reset();
      mem_lat = 1; bus.inst_ready = 1'b1; fetch_en = 1'b1;
      tick();
      redirect_valid = 1'b1; redirect_base = 64'hFFFF_FFFF_FFFF_FFF0; redirect_offset = 64'hC;
      tick();
      redirect_valid = 1'b0;
      wait_pop(30, ok, pc, d, at);
      tests++; if (!ok || pc !== 64'hFFFF_FFFF_FFFF_FFFC || d !== 32'hA5A5_FFFC) begin fails++; $display("FAIL wrap_top: pc %h data %h expected fffffffffffffffc / a5a5fffc", pc, d); end
      wait_pop(30, ok, pc, d, at);
      tests++; if (!ok || pc !== 64'h0 || d !== 32'h5A5A_0000) begin fails++; $display("FAIL wrap_zero: pc %h data %h expected 0 / 5a5a0000", pc, d); end
      tests++; if (err !== 2'b00) begin fails++; $display("FAIL wrap_err: got %b expected 00", err); end
   endtask

   task automatic test_drain();
      int cnt; logic hs; logic ok; logic [XLEN-1:0] pc; logic [ILEN-1:0] d; int at;
      logic [XLEN-1:0] exp_pc [3];
      exp_pc = '{64'h0, 64'h4, 64'h8};
      do_reset();
      mem_lat = 3; bus.inst_ready = 1'b0; fetch_en = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         hs = bus.imem_req_valid && bus.imem_req_ready;
         tick();
         if (hs) cnt++;
         if (cnt >= 2) fetch_en = 1'b0;
      end
      tests++; if (cnt != 3) begin fails++; $display("FAIL drain_requests: got %0d expected 3", cnt); end
      tests++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL drain_idle: got %b expected 0", bus.imem_req_valid); end
      bus.inst_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_pop(10, ok, pc, d, at);
         tests++; if (!ok || pc !== exp_pc[k]) begin fails++; $display("FAIL drain_pc[%0d]: got %h (ok=%b) expected %h", k, pc, ok, exp_pc[k]); end
      end
      repeat (2) tick();
      tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b expected 0", bus.inst_valid); end
   endtask

   initial begin
      bus.inst_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_misaligned();
      test_spurious();
      test_wrap();
      test_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
